bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter: BURST, 4, max RAM words granted to one owner before re-arbitration (legal 1..15).
REQ-002 SHALL have ports (clock and reset first):
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- dREN  in  2  dcache read request, bit c = core c
- dWEN  in  2  dcache write request, per core
- daddr  in  64  dcache word address, [32c+31:32c] = core c
- dstore  in  64  dcache write data, per core
- iREN  in  2  icache read request, per core
- iaddr  in  64  icache word address, per core
- ram_ready  in  1  RAM completes current word this cycle
- ramload  in  32  RAM read data
- dwait  out  2  dcache stall, per core
- iwait  out  2  icache stall, per core
- dload  out  64  dcache read data, per core
- iload  out  64  icache read data, per core
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- owner  out  3  {valid, is_icache, core}; valid=0 when idle

Function
REQ-003 SHALL be a 2-state FSM: IDLE, BUSY.
REQ-004 IDLE: if any request pending, SHALL register winner into owner, clear word counter, go BUSY next cycle; no RAM strobe in IDLE.
REQ-005 Arbitration priority: any dcache request (dREN|dWEN) beats any icache request.
REQ-006 Within a class, SHALL round-robin: core not served last in that class wins when both request; per-class last-served pointer updates on each grant.
REQ-007 BUSY: ramREN/ramWEN/ramaddr/ramstore SHALL follow owner's live request signals combinationally; dcache with dREN and dWEN both high -> ramWEN=1, ramREN=0.
REQ-008 Owner's wait SHALL equal ~ram_ready in BUSY; every non-owner wait SHALL be 1 whenever its request is high.
REQ-009 dload/iload for all ports SHALL broadcast ramload every cycle; meaningful only when that port's wait=0.
REQ-010 Each cycle in BUSY with ram_ready=1 SHALL increment 4-bit word counter.
REQ-011 BUSY -> IDLE when ram_ready=1 and counter == BURST-1 (burst cap), or when owner's request is low (released/aborted, counter not incremented, no strobe driven).
REQ-012 Owner request dropping same cycle as ram_ready: no transfer counted, no strobe; return IDLE.
REQ-013 Ports with no request SHALL see wait=1 only if requesting; idle ports wait=0 (don't care) -- fixed at 0.
REQ-014 Owner changing address mid-burst SHALL be forwarded unchanged; arbiter does not latch address/data.
REQ-015 Arbitration latency: request to first RAM strobe = 1 cycle when IDLE; re-arbitration after release costs 1 IDLE cycle.
REQ-016 Starvation bound: any requester SHALL be granted within 3 bursts of same-or-higher class traffic (icache only starves under continuous dcache traffic, by design).

Reset
REQ-017 On nRST low, asynchronously: state IDLE, owner=0, counter=0, both round-robin pointers = core 1 (so core 0 wins first tie), all RAM strobes 0, ramaddr/ramstore 0, dwait/iwait = requests (1 if requesting).
REQ-018 Reset mid-burst SHALL drop strobes immediately; no partial-state retention.

Verification
REQ-019 Single dcache0 read 0x100, ram_ready high 1 cycle later -> ramREN=1, ramaddr=0x100, dwait[0]=0 that cycle, return IDLE.
REQ-020 dREN[0], dREN[1], iREN[0] all high from reset, ram_ready=1 always, BURST=4 -> grants dcache0 (4 words), dcache1 (4), dcache0...; iwait[0] stays 1.
REQ-021 dcache1 dWEN=1, dstore=0xDEADBEEF, addr 0x3100 -> ramWEN=1, ramstore=0xDEADBEEF, ramaddr=0x3100.
REQ-022 Owner drops request while ram_ready=0 -> next cycle IDLE, no strobe, other pending requester granted cycle after.
REQ-023 nRST asserted in BUSY with ramWEN=1 -> ramWEN=0 same cycle, owner=0; after release, core 0 wins tie.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-core, two-class RAM arbiter: dcache traffic beats icache traffic, round-robin
// between cores within a class, and owners are capped at BURST words per grant.
module bus_arbiter #(
   parameter int unsigned BURST = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [1:0]  dREN,
   input  logic [1:0]  dWEN,
   input  logic [63:0] daddr,
   input  logic [63:0] dstore,
   input  logic [1:0]  iREN,
   input  logic [63:0] iaddr,
   input  logic        ram_ready,
   input  logic [31:0] ramload,
   output logic [1:0]  dwait,
   output logic [1:0]  iwait,
   output logic [63:0] dload,
   output logic [63:0] iload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   output logic [2:0]  owner
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam logic [3:0] BURST_LAST = 4'(BURST - 1);

   state_t      state, state_nxt;
   logic [2:0]  owner_nxt;
   logic [3:0]  count, count_nxt;
   logic        d_last, d_last_nxt;
   logic        i_last, i_last_nxt;
   logic        win_core;

   logic [1:0]  d_req;
   logic        own_core, own_icache, own_req, active;

   assign d_req      = dREN | dWEN;
   assign own_core   = owner[0];
   assign own_icache = owner[1];
   assign own_req    = own_icache ? iREN[own_core] : d_req[own_core];
   assign active     = (state == BUSY) && own_req;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= IDLE;
         owner  <= 3'b000;
         count  <= 4'd0;
         d_last <= 1'b1;
         i_last <= 1'b1;
      end else begin
         state  <= state_nxt;
         owner  <= owner_nxt;
         count  <= count_nxt;
         d_last <= d_last_nxt;
         i_last <= i_last_nxt;
      end
   end

   // NOTE: every signal written here gets a default first; a path that left one
   // unassigned would infer a latch.
   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      count_nxt  = count;
      d_last_nxt = d_last;
      i_last_nxt = i_last;
      win_core   = 1'b0;
      case (state)
         IDLE: begin
            if (|d_req) begin
               win_core   = (&d_req) ? ~d_last : d_req[1];
               owner_nxt  = {1'b1, 1'b0, win_core};
               d_last_nxt = win_core;
               count_nxt  = 4'd0;
               state_nxt  = BUSY;
            end else if (|iREN) begin
               win_core   = (&iREN) ? ~i_last : iREN[1];
               owner_nxt  = {1'b1, 1'b1, win_core};
               i_last_nxt = win_core;
               count_nxt  = 4'd0;
               state_nxt  = BUSY;
            end
         end
         BUSY: begin
            // A dropped request ends the grant without counting a word.
            if (!own_req) begin
               state_nxt = IDLE;
               owner_nxt = 3'b000;
            end else if (ram_ready) begin
               if (count == BURST_LAST) begin
                  state_nxt = IDLE;
                  owner_nxt = 3'b000;
               end else begin
                  count_nxt = count + 4'd1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            owner_nxt = 3'b000;
         end
      endcase
   end

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = 32'd0;
      ramstore = 32'd0;
      dwait    = d_req;
      iwait    = iREN;
      if (active) begin
         if (own_icache) begin
            ramREN             = 1'b1;
            ramaddr            = own_core ? iaddr[63:32] : iaddr[31:0];
            iwait[own_core]    = ~ram_ready;
         end else begin
            // Write wins when a core raises both dREN and dWEN.
            ramWEN             = dWEN[own_core];
            ramREN             = dREN[own_core] & ~dWEN[own_core];
            ramaddr            = own_core ? daddr[63:32]  : daddr[31:0];
            ramstore           = own_core ? dstore[63:32] : dstore[31:0];
            dwait[own_core]    = ~ram_ready;
         end
      end
   end

   assign dload = {ramload, ramload};
   assign iload = {ramload, ramload};

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios plus random traffic,
// expected outputs from a grant-level reference model, compared on the falling edge.
module tb_bus_arbiter;

   localparam int BURST = 4;

   logic        CLK, nRST;
   logic [1:0]  dREN, dWEN, iREN;
   logic [63:0] daddr, dstore, iaddr;
   logic        ram_ready;
   logic [31:0] ramload;
   logic [1:0]  dwait, iwait;
   logic [63:0] dload, iload;
   logic        ramREN, ramWEN;
   logic [31:0] ramaddr, ramstore;
   logic [2:0]  owner;

   bus_arbiter #(.BURST(BURST)) dut (
      .CLK(CLK), .nRST(nRST),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .iREN(iREN), .iaddr(iaddr),
      .ram_ready(ram_ready), .ramload(ramload),
      .dwait(dwait), .iwait(iwait), .dload(dload), .iload(iload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .owner(owner)
   );

   initial CLK = 1'b1;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [2:0]  owner;
      logic        ren, wen;
      logic [31:0] addr, store;
      logic [1:0]  dwait, iwait;
      logic [63:0] load;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: who holds the bus, how many words it has moved, and
   // which core is preferred on the next tie in each class.
   bit m_busy;
   bit m_icache;
   bit m_core;
   int m_words;
   bit m_pref_d, m_pref_i;

   task automatic model_reset();
      m_busy   = 1'b0;
      m_icache = 1'b0;
      m_core   = 1'b0;
      m_words  = 0;
      m_pref_d = 1'b0;
      m_pref_i = 1'b0;
   endtask

   function automatic bit owner_requesting();
      if (!m_busy) return 1'b0;
      if (m_icache) return iREN[m_core];
      return dREN[m_core] | dWEN[m_core];
   endfunction

   task automatic push_expect();
      exp_t e;
      bit   req;
      req     = owner_requesting();
      e.owner = m_busy ? {1'b1, m_icache, m_core} : 3'b000;
      e.ren   = 1'b0;
      e.wen   = 1'b0;
      e.addr  = 32'd0;
      e.store = 32'd0;
      e.dwait = dREN | dWEN;
      e.iwait = iREN;
      e.load  = {ramload, ramload};
      if (req) begin
         if (m_icache) begin
            e.ren  = 1'b1;
            e.addr = m_core ? iaddr[63:32] : iaddr[31:0];
            e.iwait[m_core] = ~ram_ready;
         end else begin
            e.wen   = dWEN[m_core];
            e.ren   = ~dWEN[m_core];
            e.addr  = m_core ? daddr[63:32]  : daddr[31:0];
            e.store = m_core ? dstore[63:32] : dstore[31:0];
            e.dwait[m_core] = ~ram_ready;
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic model_step();
      logic [1:0] dr;
      dr = dREN | dWEN;
      if (!nRST) begin
         model_reset();
      end else if (!m_busy) begin
         if (dr != 2'b00) begin
            m_icache = 1'b0;
            m_core   = (dr == 2'b11) ? m_pref_d : dr[1];
            m_pref_d = ~m_core;
            m_busy   = 1'b1;
            m_words  = 0;
         end else if (iREN != 2'b00) begin
            m_icache = 1'b1;
            m_core   = (iREN == 2'b11) ? m_pref_i : iREN[1];
            m_pref_i = ~m_core;
            m_busy   = 1'b1;
            m_words  = 0;
         end
      end else if (!owner_requesting()) begin
         m_busy = 1'b0;
      end else if (ram_ready) begin
         m_words++;
         if (m_words == BURST) m_busy = 1'b0;
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: the design presents a full output set every cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("owner",    64'(owner),    64'(e.owner));
            check("ramREN",   64'(ramREN),   64'(e.ren));
            check("ramWEN",   64'(ramWEN),   64'(e.wen));
            check("ramaddr",  64'(ramaddr),  64'(e.addr));
            check("ramstore", 64'(ramstore), 64'(e.store));
            check("dwait",    64'(dwait),    64'(e.dwait));
            check("iwait",    64'(iwait),    64'(e.iwait));
            check("dload",    dload,         e.load);
            check("iload",    iload,         e.load);
         end
      end
   end

   // One cycle: publish expectations for the current inputs, then advance the model.
   task automatic tick();
      push_expect();
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic clear_req();
      dREN = 2'b00;
      dWEN = 2'b00;
      iREN = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      nRST = 1'b0;
      clear_req();
      daddr = '0; dstore = '0; iaddr = '0;
      ram_ready = 1'b0;
      ramload = 32'h1234_5678;
      model_reset();

      // Reset: waits mirror requests, no strobes.
      tick();
      dREN = 2'b10; iREN = 2'b01;
      tick();
      clear_req();
      nRST = 1'b1;
      tick();

      // Single dcache0 read at 0x100.
      dREN = 2'b01; daddr = 64'h0000_0000_0000_0100;
      tick();
      ram_ready = 1'b1;
      tick();
      clear_req(); ram_ready = 1'b0;
      tick();
      tick();

      // dcache1 write of 0xDEADBEEF to 0x3100.
      dWEN = 2'b10; daddr = 64'h0000_3100_0000_0000; dstore = 64'hDEAD_BEEF_0000_0000;
      tick();
      tick();
      ram_ready = 1'b1;
      tick();
      clear_req(); ram_ready = 1'b0;
      tick();

      // Two dcache cores plus icache0 under continuous ram_ready.
      dREN = 2'b11; iREN = 2'b01; ram_ready = 1'b1;
      daddr = 64'h0000_0200_0000_0300; iaddr = 64'h0000_0000_0000_0400;
      for (int i = 0; i < 16; i++) begin
         ramload = $urandom;
         tick();
      end
      clear_req(); ram_ready = 1'b0;
      tick();

      // Owner abandons while RAM is stalled; the other core takes over.
      dREN = 2'b11;
      tick();
      tick();
      dREN = 2'b10;
      tick();
      tick();
      tick();
      clear_req();
      tick();
      tick();

      // Reset in the middle of a write burst, then core 0 wins the tie.
      dWEN = 2'b01; dstore = 64'h0000_0000_CAFE_F00D;
      tick();
      tick();
      nRST = 1'b0;
      model_reset();
      tick();
      nRST = 1'b1; clear_req(); dREN = 2'b11;
      tick();
      tick();
      clear_req();
      tick();

      // Random traffic with persistent requests and occasional resets.
      for (int i = 0; i < 2000; i++) begin
         for (int c = 0; c < 2; c++) begin
            if ($urandom_range(7) == 0)  dREN[c] = ~dREN[c];
            if ($urandom_range(15) == 0) dWEN[c] = ~dWEN[c];
            if ($urandom_range(5) == 0)  iREN[c] = ~iREN[c];
         end
         daddr     = {$urandom, $urandom};
         dstore    = {$urandom, $urandom};
         iaddr     = {$urandom, $urandom};
         ramload   = $urandom;
         ram_ready = ($urandom_range(3) != 0);
         if ($urandom_range(299) == 0) begin
            nRST = 1'b0;
            model_reset();
         end else begin
            nRST = 1'b1;
         end
         tick();
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
